// File: rtl/if_logic_gen.sv
`default_nettype none
// ============================================================================
//  Module   : if_logic_gen (with helper if_logic_gen_fifo)
//  Purpose  : Compute-tile <-> external memory interface logic.
//             Load path : external tokens -> load FIFO -> tile.
//             Store path: header capture -> O_Req, payload -> store FIFO
//                         -> external side once the store path is granted.
//  Options  : IF_LOGIC_GEN_PERF_EN adds O_Ld_Words / O_St_Words counters.
//  Revision : 1.0  initial parametrised release
// ============================================================================

module if_logic_gen_fifo #(
    parameter int W      = 34,
    parameter int DEPTH  = 16,
    parameter int THRESH = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_nack,
    output logic         o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL     = (AW+1)'(DEPTH);
    // Fill level at which free entries drop to THRESH or below
    localparam logic [AW:0] c_NACK_LVL = (THRESH >= DEPTH) ? '0 : (AW+1)'(DEPTH - THRESH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          w_full;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == c_FULL);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees a slot, so full+push+pop still succeeds
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_ovf     = i_push & ~w_do_push;
    assign o_nack    = (r_cnt >= c_NACK_LVL);
    assign o_dout    = r_mem[r_rd_ptr];

    // Storage array write port
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module if_logic_gen #(
    parameter int WIDTH_DATA = 32,
    parameter int DEPTH_LD   = 16,
    parameter int DEPTH_ST   = 16,
    parameter int THRESHOLD  = 6,
    parameter int NUM_HDR    = 4,
    parameter int CNT_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Ld,
    input  logic                  I_St,
    input  logic                  I_Ld_V,
    input  logic                  I_Ld_A,
    input  logic                  I_Ld_R,
    input  logic [WIDTH_DATA-1:0] I_Ld_D,
    output logic                  O_Ld_N,
    output logic                  O_Ld_V,
    output logic                  O_Ld_A,
    output logic                  O_Ld_R,
    output logic [WIDTH_DATA-1:0] O_Ld_D,
    input  logic                  I_Ld_N,
    input  logic                  I_St_V,
    input  logic                  I_St_A,
    input  logic                  I_St_R,
    input  logic [WIDTH_DATA-1:0] I_St_D,
    output logic                  O_St_N,
    output logic                  O_St_V,
    output logic                  O_St_A,
    output logic                  O_St_R,
    output logic [WIDTH_DATA-1:0] O_St_D,
    input  logic                  I_St_N,
    output logic                  O_Req_V,
    output logic [WIDTH_DATA-1:0] O_Req_D,
    output logic                  O_Header,
    output logic                  O_Ld_Active,
    output logic [CNT_W-1:0]      O_Ld_Cnt,
    output logic                  O_Err_Ovf
`ifdef IF_LOGIC_GEN_PERF_EN
    ,
    output logic [15:0]           O_Ld_Words,
    output logic [15:0]           O_St_Words
`endif
);
    localparam int TW = WIDTH_DATA + 2;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HDR  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_RUN  = 2'd3;
    localparam logic [3:0] c_NUM_HDR = 4'(NUM_HDR);

    // ---------------- Load path ----------------
    logic [TW-1:0]    w_ld_head;
    logic             w_ld_empty;
    logic             w_ld_nack;
    logic             w_ld_ovf;
    logic             w_ld_out_v;
    logic             w_ld_acq_in;
    logic             w_ld_term_dlv;
    logic             r_ld_active;
    logic [CNT_W-1:0] r_ld_cnt;

    if_logic_gen_fifo #(
        .W      (TW),
        .DEPTH  (DEPTH_LD),
        .THRESH (THRESHOLD)
    ) u_ld_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (I_Ld_V),
        .i_din   ({I_Ld_A, I_Ld_R, I_Ld_D}),
        .i_pop   (w_ld_out_v & ~I_Ld_N),
        .o_dout  (w_ld_head),
        .o_empty (w_ld_empty),
        .o_nack  (w_ld_nack),
        .o_ovf   (w_ld_ovf)
    );

    // Head is only exposed to the tile while a load is open and granted
    assign w_ld_out_v    = r_ld_active & I_Ld & ~w_ld_empty;
    assign w_ld_acq_in   = I_Ld_V & I_Ld_A & ~I_Ld_R;
    assign w_ld_term_dlv = w_ld_out_v & ~I_Ld_N & w_ld_head[TW-1] & w_ld_head[TW-2];

    assign O_Ld_N      = w_ld_nack;
    assign O_Ld_V      = w_ld_out_v;
    assign O_Ld_A      = w_ld_out_v & w_ld_head[TW-1];
    assign O_Ld_R      = w_ld_out_v & w_ld_head[TW-2];
    assign O_Ld_D      = w_ld_out_v ? w_ld_head[WIDTH_DATA-1:0] : '0;
    assign O_Ld_Active = r_ld_active;
    assign O_Ld_Cnt    = r_ld_cnt;

    // Load activity flag and saturating in-flight sequence counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ld_active <= 1'b0;
            r_ld_cnt    <= '0;
        end else begin
            if (w_ld_acq_in)        r_ld_active <= 1'b1;
            else if (w_ld_term_dlv) r_ld_active <= 1'b0;

            if (w_ld_acq_in && !w_ld_term_dlv) begin
                if (r_ld_cnt != '1) r_ld_cnt <= r_ld_cnt + CNT_W'(1);
            end else if (!w_ld_acq_in && w_ld_term_dlv) begin
                if (r_ld_cnt != '0) r_ld_cnt <= r_ld_cnt - CNT_W'(1);
            end
        end
    end

    // ---------------- Store path ----------------
    logic [1:0]            r_st_state;
    logic [3:0]            r_hcnt;
    logic                  r_req_v;
    logic [WIDTH_DATA-1:0] r_req_d;
    logic                  r_ovf;
    logic [TW-1:0]         w_st_head;
    logic                  w_st_empty;
    logic                  w_st_fifo_nack;
    logic                  w_st_ovf;
    logic                  w_st_acq;
    logic                  w_st_buf;
    logic                  w_st_out_v;
    logic                  w_st_term_dlv;
    logic                  w_st_nack;

    assign w_st_acq      = I_St_V & I_St_A & ~I_St_R;
    assign w_st_buf      = (r_st_state == c_WAIT) | (r_st_state == c_RUN);
    assign w_st_out_v    = (r_st_state == c_RUN) & ~w_st_empty;
    assign w_st_term_dlv = w_st_out_v & ~I_St_N & w_st_head[TW-1] & w_st_head[TW-2];

    if_logic_gen_fifo #(
        .W      (TW),
        .DEPTH  (DEPTH_ST),
        .THRESH (THRESHOLD)
    ) u_st_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (I_St_V & w_st_buf),
        .i_din   ({I_St_A, I_St_R, I_St_D}),
        .i_pop   (w_st_out_v & ~I_St_N),
        .o_dout  (w_st_head),
        .o_empty (w_st_empty),
        .o_nack  (w_st_fifo_nack),
        .o_ovf   (w_st_ovf)
    );

    // Nack to the tile: IDLE refuses anything but an acquire, HDR always accepts
    always_comb begin
        w_st_nack = 1'b0;
        case (r_st_state)
            c_IDLE:  w_st_nack = I_St_V & ~(I_St_A & ~I_St_R);
            c_HDR:   w_st_nack = 1'b0;
            default: w_st_nack = w_st_fifo_nack;
        endcase
    end

    assign O_St_N   = w_st_nack;
    assign O_St_V   = w_st_out_v;
    assign O_St_A   = w_st_out_v & w_st_head[TW-1];
    assign O_St_R   = w_st_out_v & w_st_head[TW-2];
    assign O_St_D   = w_st_out_v ? w_st_head[WIDTH_DATA-1:0] : '0;
    assign O_Req_V  = r_req_v;
    assign O_Req_D  = r_req_d;
    assign O_Header = (r_st_state == c_HDR) | ((r_st_state == c_IDLE) & w_st_acq);
    assign O_Err_Ovf = r_ovf;

    // Store FSM: header capture, wait for grant, then stream the payload
    always_ff @(posedge clock) begin
        if (reset) begin
            r_st_state <= c_IDLE;
            r_hcnt     <= '0;
            r_req_v    <= 1'b0;
            r_req_d    <= '0;
        end else begin
            r_req_v <= 1'b0;
            r_req_d <= '0;
            case (r_st_state)
                c_IDLE: begin
                    if (w_st_acq) begin
                        r_req_v    <= 1'b1;
                        r_req_d    <= I_St_D;
                        r_hcnt     <= 4'd1;
                        r_st_state <= (c_NUM_HDR == 4'd1) ? c_WAIT : c_HDR;
                    end
                end
                c_HDR: begin
                    if (I_St_V) begin
                        r_req_v <= 1'b1;
                        r_req_d <= I_St_D;
                        r_hcnt  <= r_hcnt + 4'd1;
                        if (r_hcnt + 4'd1 == c_NUM_HDR) r_st_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (I_St) r_st_state <= c_RUN;
                end
                c_RUN: begin
                    if (w_st_term_dlv) r_st_state <= c_IDLE;
                end
                default: r_st_state <= c_IDLE;
            endcase
        end
    end

    // Sticky overflow flag from either FIFO
    always_ff @(posedge clock) begin
        if (reset) r_ovf <= 1'b0;
        else if (w_ld_ovf | w_st_ovf) r_ovf <= 1'b1;
    end

`ifdef IF_LOGIC_GEN_PERF_EN
    logic [15:0] r_ld_words;
    logic [15:0] r_st_words;

    assign O_Ld_Words = r_ld_words;
    assign O_St_Words = r_st_words;

    // Wrapping counts of data tokens delivered on each side
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ld_words <= '0;
            r_st_words <= '0;
        end else begin
            if (w_ld_out_v & ~I_Ld_N & ~w_ld_head[TW-1]) r_ld_words <= r_ld_words + 16'd1;
            if (w_st_out_v & ~I_St_N & ~w_st_head[TW-1]) r_st_words <= r_st_words + 16'd1;
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_if_logic_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_logic_gen
//  Purpose  : Self-checking bench for if_logic_gen (table vectors + scoreboard)
//  Revision : 1.0
// ============================================================================
module tb_if_logic_gen;
    logic        clock = 1'b0;
    logic        reset;
    logic        I_Ld, I_St;
    logic        I_Ld_V, I_Ld_A, I_Ld_R;
    logic [31:0] I_Ld_D;
    logic        O_Ld_N, O_Ld_V, O_Ld_A, O_Ld_R;
    logic [31:0] O_Ld_D;
    logic        I_Ld_N;
    logic        I_St_V, I_St_A, I_St_R;
    logic [31:0] I_St_D;
    logic        O_St_N, O_St_V, O_St_A, O_St_R;
    logic [31:0] O_St_D;
    logic        I_St_N;
    logic        O_Req_V;
    logic [31:0] O_Req_D;
    logic        O_Header, O_Ld_Active;
    logic [3:0]  O_Ld_Cnt;
    logic        O_Err_Ovf;
`ifdef IF_LOGIC_GEN_PERF_EN
    logic [15:0] O_Ld_Words, O_St_Words;
`endif

    if_logic_gen dut (
        .clock(clock), .reset(reset), .I_Ld(I_Ld), .I_St(I_St),
        .I_Ld_V(I_Ld_V), .I_Ld_A(I_Ld_A), .I_Ld_R(I_Ld_R), .I_Ld_D(I_Ld_D),
        .O_Ld_N(O_Ld_N), .O_Ld_V(O_Ld_V), .O_Ld_A(O_Ld_A), .O_Ld_R(O_Ld_R),
        .O_Ld_D(O_Ld_D), .I_Ld_N(I_Ld_N),
        .I_St_V(I_St_V), .I_St_A(I_St_A), .I_St_R(I_St_R), .I_St_D(I_St_D),
        .O_St_N(O_St_N), .O_St_V(O_St_V), .O_St_A(O_St_A), .O_St_R(O_St_R),
        .O_St_D(O_St_D), .I_St_N(I_St_N),
        .O_Req_V(O_Req_V), .O_Req_D(O_Req_D), .O_Header(O_Header),
        .O_Ld_Active(O_Ld_Active), .O_Ld_Cnt(O_Ld_Cnt), .O_Err_Ovf(O_Err_Ovf)
`ifdef IF_LOGIC_GEN_PERF_EN
        , .O_Ld_Words(O_Ld_Words), .O_St_Words(O_St_Words)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    logic [33:0] ld_q[$];
    logic [33:0] st_q[$];
    logic [31:0] req_q[$];

    typedef struct {
        logic v, a, r; logic [31:0] d;
        logic e_v, e_act; logic [3:0] e_cnt;
    } ld_vec_t;

    typedef struct {
        logic v, a, r; logic [31:0] d; logic ist;
        logic to_req, to_st;
        logic e_hdr, e_stn, e_stv;
    } st_vec_t;

    ld_vec_t ld_tab[7];
    st_vec_t st_tab[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare every delivered token against the expected queues
    always @(negedge clock) begin
        if (O_Ld_V && !I_Ld_N) begin
            if (ld_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL ld_extra: actual %0h required none", {O_Ld_A, O_Ld_R, O_Ld_D});
            end else begin
                chk("ld_token", {O_Ld_A, O_Ld_R, O_Ld_D}, ld_q.pop_front());
            end
        end
        if (O_St_V && !I_St_N) begin
            if (st_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL st_extra: actual %0h required none", {O_St_A, O_St_R, O_St_D});
            end else begin
                chk("st_token", {O_St_A, O_St_R, O_St_D}, st_q.pop_front());
            end
        end
        if (O_Req_V) begin
            if (req_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL req_extra: actual %0h required none", O_Req_D);
            end else begin
                chk("req_word", O_Req_D, req_q.pop_front());
            end
        end
    end

    task automatic all_zero(input string name);
        chk(name, {O_Ld_N, O_Ld_V, O_Ld_A, O_Ld_R, O_Ld_D, O_St_N, O_St_V, O_St_A, O_St_R,
                   O_St_D, O_Req_V, O_Req_D, O_Header, O_Ld_Active, O_Ld_Cnt, O_Err_Ovf}, '0);
    endtask

    task automatic st_send(input logic a, input logic r, input logic [31:0] d,
                           input logic to_req, input logic to_st);
        I_St_V = 1'b1; I_St_A = a; I_St_R = r; I_St_D = d;
        if (to_req) req_q.push_back(d);
        if (to_st)  st_q.push_back({a, r, d});
        tick;
        I_St_V = 1'b0; I_St_A = 1'b0; I_St_R = 1'b0; I_St_D = '0;
    endtask

    task automatic st_header(input logic [31:0] base);
        st_send(1'b1, 1'b0, base, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) st_send(1'b0, 1'b0, base + i, 1'b1, 1'b0);
    endtask

    task automatic go_run(input string name);
        I_St = 1'b1;
        tick;
        chk(name, O_St_V, 1'b1);
    endtask

    task automatic drain_st(input string name, input bit toggle);
        int n = 0;
        while (st_q.size() != 0 && n < 200) begin
            if (toggle) I_St_N = ~I_St_N;
            tick;
            n++;
        end
        chk(name, st_q.size(), 0);
        I_St_N = 1'b0;
        tick;
        tick;
        I_St = 1'b0;
    endtask

    // In IDLE a non-acquire token must be refused and no header flagged
    task automatic check_st_idle(input string name);
        I_St_V = 1'b1; I_St_A = 1'b0; I_St_R = 1'b0; I_St_D = 32'h5A;
        #1;
        chk(name, {O_St_N, O_Header}, 2'b10);
        I_St_V = 1'b0; I_St_D = '0;
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: actual hang required completion");
        $fatal(1);
    end

    initial begin
        int written, sent, n, hi_at;
        bit seen;

        ld_tab[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 4'd1};
        ld_tab[1] = '{1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 1'b1, 4'd1};
        ld_tab[2] = '{1'b1, 1'b0, 1'b0, 32'h22, 1'b1, 1'b1, 4'd1};
        ld_tab[3] = '{1'b1, 1'b0, 1'b0, 32'h33, 1'b1, 1'b1, 4'd1};
        ld_tab[4] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b1, 1'b1, 4'd1};
        ld_tab[5] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0};
        ld_tab[6] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0};

        st_tab[0] = '{1'b1, 1'b1, 1'b0, 32'hA0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        st_tab[1] = '{1'b1, 1'b0, 1'b0, 32'hA1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        st_tab[2] = '{1'b1, 1'b0, 1'b0, 32'hA2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        st_tab[3] = '{1'b1, 1'b0, 1'b0, 32'hA3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        st_tab[4] = '{1'b1, 1'b0, 1'b0, 32'hD0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        st_tab[5] = '{1'b1, 1'b0, 1'b0, 32'hD1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        st_tab[6] = '{1'b1, 1'b0, 1'b0, 32'hD2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        st_tab[7] = '{1'b1, 1'b0, 1'b0, 32'hD3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        st_tab[8] = '{1'b1, 1'b1, 1'b1, 32'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; I_Ld = 1'b1; I_St = 1'b0;
        I_Ld_V = 0; I_Ld_A = 0; I_Ld_R = 0; I_Ld_D = '0; I_Ld_N = 0;
        I_St_V = 0; I_St_A = 0; I_St_R = 0; I_St_D = '0; I_St_N = 0;
        tick;
        tick;
        all_zero("reset_state");
        reset = 1'b0;
        tick;

        // Load: acquire, three data words, terminator
        foreach (ld_tab[i]) begin
            I_Ld_V = ld_tab[i].v; I_Ld_A = ld_tab[i].a; I_Ld_R = ld_tab[i].r; I_Ld_D = ld_tab[i].d;
            if (ld_tab[i].v) ld_q.push_back({ld_tab[i].a, ld_tab[i].r, ld_tab[i].d});
            tick;
            chk($sformatf("ld_v_%0d", i), O_Ld_V, ld_tab[i].e_v);
            chk($sformatf("ld_active_%0d", i), O_Ld_Active, ld_tab[i].e_act);
            chk($sformatf("ld_cnt_%0d", i), O_Ld_Cnt, ld_tab[i].e_cnt);
        end
        chk("ld_basic_drain", ld_q.size(), 0);
`ifdef IF_LOGIC_GEN_PERF_EN
        chk("ld_words", O_Ld_Words, 16'd3);
`endif

        // Load backpressure: sender obeys nack while the tile stalls
        I_Ld_N = 1'b1;
        I_Ld_V = 1; I_Ld_A = 1; I_Ld_R = 0; I_Ld_D = '0;
        ld_q.push_back({1'b1, 1'b0, 32'h0});
        tick;
        I_Ld_V = 0; I_Ld_A = 0;
        written = 1; sent = 0; n = 0; seen = 0; hi_at = 0;
        while ((sent < 17 || ld_q.size() != 0) && n < 300) begin
            if (O_Ld_N && !seen) begin
                seen = 1;
                hi_at = n;
                chk("ld_nack_level", written, 16 - 6);
            end
            if (seen && n == hi_at + 3) I_Ld_N = 1'b0;
            if (!O_Ld_N && sent < 17) begin
                I_Ld_V = 1'b1;
                I_Ld_A = (sent == 16);
                I_Ld_R = (sent == 16);
                I_Ld_D = 32'h100 + sent;
                ld_q.push_back({I_Ld_A, I_Ld_R, I_Ld_D});
                sent++;
                written++;
            end else begin
                I_Ld_V = 1'b0;
            end
            tick;
            n++;
        end
        I_Ld_V = 0; I_Ld_A = 0; I_Ld_R = 0;
        chk("ld_nack_seen", seen, 1'b1);
        chk("ld_bp_drain", ld_q.size(), 0);
        tick;
        tick;
        chk("ld_bp_end", {O_Ld_Active, O_Ld_Cnt}, 5'd0);

        // Overflow: fill past full with the tile stalled
        I_Ld_N = 1'b1;
        for (int i = 0; i < 16; i++) begin
            I_Ld_V = 1'b1; I_Ld_D = 32'h200 + i;
            tick;
        end
        chk("ovf_before", {O_Err_Ovf, O_Ld_N}, 2'b01);
        I_Ld_D = 32'h2FF;
        tick;
        I_Ld_V = 1'b0;
        chk("ovf_set", O_Err_Ovf, 1'b1);
        tick;
        chk("ovf_sticky", O_Err_Ovf, 1'b1);
        I_Ld_N = 1'b0;

        // Store: header collection, buffered payload, late grant
        foreach (st_tab[i]) begin
            I_St_V = st_tab[i].v; I_St_A = st_tab[i].a; I_St_R = st_tab[i].r;
            I_St_D = st_tab[i].d; I_St = st_tab[i].ist;
            if (st_tab[i].to_req) req_q.push_back(st_tab[i].d);
            if (st_tab[i].to_st)  st_q.push_back({st_tab[i].a, st_tab[i].r, st_tab[i].d});
            #1;
            chk($sformatf("st_hdr_%0d", i), O_Header, st_tab[i].e_hdr);
            chk($sformatf("st_nack_%0d", i), O_St_N, st_tab[i].e_stn);
            tick;
            chk($sformatf("st_v_%0d", i), O_St_V, st_tab[i].e_stv);
        end
        I_St_V = 0; I_St_A = 0; I_St_R = 0; I_St_D = '0;
        drain_st("st_basic_drain", 1'b0);
        check_st_idle("st_basic_idle");
        chk("req_basic_seen", req_q.size(), 0);
`ifdef IF_LOGIC_GEN_PERF_EN
        chk("st_words", O_St_Words, 16'd4);
`endif

        // Store with external nack toggling every cycle during RUN
        st_header(32'hB0);
        for (int i = 0; i < 6; i++) st_send(1'b0, 1'b0, 32'hC0 + i, 1'b0, 1'b1);
        st_send(1'b1, 1'b1, 32'hCF, 1'b0, 1'b1);
        go_run("st_toggle_run");
        drain_st("st_toggle_drain", 1'b1);
        check_st_idle("st_toggle_idle");

        // Reset in the middle of RUN with five words buffered
        st_header(32'hE0);
        for (int i = 0; i < 5; i++) st_send(1'b0, 1'b0, 32'hF0 + i, 1'b0, 1'b0);
        I_St_N = 1'b1;
        go_run("st_pre_reset_run");
        I_St = 1'b0;
        reset = 1'b1;
        tick;
        all_zero("mid_run_reset");
        reset = 1'b0;
        I_St_N = 1'b0;
        tick;
        st_header(32'h70);
        st_send(1'b0, 1'b0, 32'h81, 1'b0, 1'b1);
        st_send(1'b0, 1'b0, 32'h82, 1'b0, 1'b1);
        st_send(1'b1, 1'b1, 32'h8F, 1'b0, 1'b1);
        go_run("st_restart_run");
        drain_st("st_restart_drain", 1'b0);
        check_st_idle("st_restart_idle");
        chk("req_all_seen", req_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
